// File: rtl/rx_detect_ctrl_pkg.sv
// Shared definitions for the receiver-detect sequencer: state encodings,
// RXSTATUS codes (also used by the status encoder) and the vote helper.
package rx_detect_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_DETECT   = 3'd2,
    ST_REPORT   = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_e;

  localparam logic [2:0] RXSTAT_NONE = 3'b000;
  localparam logic [2:0] RXSTAT_DET  = 3'b011;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_detect_ctrl_load_down_counter.sv
// Loadable down-counter with async clear and a zero flag; stops at zero.
module load_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/rx_detect_ctrl.sv
// Receiver-detect sequencer: forces electrical idle, pulses RXDET for a fixed
// window, majority-votes the last three RXDET_O samples and reports via PHYSTATUS.
module rx_detect_ctrl
  import rx_detect_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int DET_WAIT   = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clock,
  input  logic       Reset_n,
  input  logic       TXDETECTRX,
  input  logic       TXELECIDLE,
  input  logic       RXDET_O,
  output logic       TXIDLE,
  output logic       RXDET,
  output logic       PHYSTATUS,
  output logic [2:0] RXSTATUS,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DET_LD    = CNT_W'(DET_WAIT - 1);
  localparam logic [CNT_W-1:0] VOTE_WIN  = CNT_W'(2);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic             w_vote_shift;
  logic             w_report;

  logic             r_txidle;
  logic             r_rxdet;
  logic             r_phystatus;
  logic [2:0]       r_rxstatus;
  logic             r_busy;
  logic [1:0]       r_vote;

  load_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk      (clock),
    .i_rst_n    (Reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    w_cnt_dec    = 1'b0;
    w_vote_shift = 1'b0;
    w_report     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A request without electrical idle is ignored (no loopback).
        if (TXDETECTRX && TXELECIDLE) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_DETECT;
          w_cnt_load  = 1'b1;
          w_cnt_val   = DET_LD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_DETECT: begin
        // Samples at counts 2 and 1 are stored; the count-0 sample is used live.
        w_vote_shift = (w_cnt <= VOTE_WIN) && !w_cnt_zero;
        if (w_cnt_zero) begin
          w_state_nxt = ST_REPORT;
          w_report    = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_REPORT: begin
        w_state_nxt = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!TXDETECTRX) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_txidle    <= 1'b1;
      r_rxdet     <= 1'b0;
      r_phystatus <= 1'b0;
      r_rxstatus  <= RXSTAT_NONE;
      r_busy      <= 1'b0;
      r_vote      <= 2'b00;
    end else begin
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_txidle    <= (w_state_nxt != ST_IDLE) | TXELECIDLE;
      r_rxdet     <= (w_state_nxt == ST_DETECT);
      r_phystatus <= w_report;
      if (w_vote_shift) begin
        r_vote <= {r_vote[0], RXDET_O};
      end
      if (w_report) begin
        r_rxstatus <= maj3(r_vote[1], r_vote[0], RXDET_O) ? RXSTAT_DET : RXSTAT_NONE;
      end
    end
  end

  assign TXIDLE    = r_txidle;
  assign RXDET     = r_rxdet;
  assign PHYSTATUS = r_phystatus;
  assign RXSTATUS  = r_rxstatus;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_rx_detect_ctrl.sv
// Randomized bench for rx_detect_ctrl against a timeline reference model.
module tb_rx_detect_ctrl;

  localparam int S = 4;
  localparam int D = 8;

  logic       clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       TXDETECTRX = 1'b0;
  logic       TXELECIDLE = 1'b1;
  logic       RXDET_O = 1'b0;
  logic       TXIDLE;
  logic       RXDET;
  logic       PHYSTATUS;
  logic [2:0] RXSTATUS;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position on the request timeline (edges since request).
  bit       m_busy;
  int       m_n;
  int       m_votes;
  bit       m_txidle;
  bit       m_rxdet;
  bit       m_phys;
  bit [2:0] m_rxstat;

  rx_detect_ctrl #(
    .SETTLE_CYC (S),
    .DET_WAIT   (D),
    .CNT_W      (8)
  ) dut (
    .clock      (clock),
    .Reset_n    (Reset_n),
    .TXDETECTRX (TXDETECTRX),
    .TXELECIDLE (TXELECIDLE),
    .RXDET_O    (RXDET_O),
    .TXIDLE     (TXIDLE),
    .RXDET      (RXDET),
    .PHYSTATUS  (PHYSTATUS),
    .RXSTATUS   (RXSTATUS),
    .BUSY       (BUSY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_n      = 0;
    m_votes  = 0;
    m_txidle = 1'b1;
    m_rxdet  = 1'b0;
    m_phys   = 1'b0;
    m_rxstat = 3'b000;
  endtask

  task automatic model_edge(input bit req, input bit eidle, input bit det);
    m_phys = 1'b0;
    if (!m_busy) begin
      if (req && eidle) begin
        m_busy  = 1'b1;
        m_n     = 0;
        m_votes = 0;
      end
      m_txidle = m_busy ? 1'b1 : eidle;
    end else begin
      m_n++;
      if (m_n >= S + D - 2 && m_n <= S + D) m_votes += int'(det);
      if (m_n == S + D) begin
        m_phys   = 1'b1;
        m_rxstat = (m_votes >= 2) ? 3'b011 : 3'b000;
      end
      if (m_n >= S + D + 2 && !req) begin
        m_busy   = 1'b0;
        m_txidle = eidle;
      end
    end
    m_rxdet = m_busy && (m_n >= S) && (m_n <= S + D - 1);
  endtask

  task automatic check_outputs();
    check("TXIDLE", 32'(TXIDLE), 32'(m_txidle));
    check("RXDET", 32'(RXDET), 32'(m_rxdet));
    check("PHYSTATUS", 32'(PHYSTATUS), 32'(m_phys));
    check("RXSTATUS", 32'(RXSTATUS), 32'(m_rxstat));
    check("BUSY", 32'(BUSY), 32'(m_busy));
  endtask

  task automatic step();
    bit req, eid, det;
    @(posedge clock);
    req = TXDETECTRX;
    eid = TXELECIDLE;
    det = RXDET_O;
    model_edge(req, eid, det);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    TXDETECTRX = 1'b0;
    for (int i = 0; i < n; i++) begin
      TXELECIDLE = 1'($urandom);
      RXDET_O    = 1'($urandom);
      step();
    end
  endtask

  task automatic run_req(input bit [2:0] pat, input int hold, input bit rnd_eidle);
    int phys_cnt;
    int phys_at;
    phys_cnt = 0;
    phys_at  = -1;
    TXELECIDLE = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i == S + D - 2)      RXDET_O = pat[2];
      else if (i == S + D - 1) RXDET_O = pat[1];
      else if (i == S + D)     RXDET_O = pat[0];
      else                     RXDET_O = 1'($urandom);
      if (i > 0 && rnd_eidle) TXELECIDLE = 1'($urandom);
      TXDETECTRX = (i <= S + D + hold);
      step();
      if (PHYSTATUS) begin
        phys_cnt++;
        if (phys_at < 0) phys_at = i;
      end
      if (hold > 0 && i == S + D + hold) check("busy_held", 32'(BUSY), 32'd1);
      if (!m_busy && i > S + D) break;
    end
    check("phys_count", phys_cnt, 1);
    check("phys_latency", phys_at, S + D);
    check("vote_result", 32'(RXSTATUS), ($countones(pat) >= 2) ? 32'd3 : 32'd0);
    TXDETECTRX = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_TXIDLE"}, 32'(TXIDLE), 32'd1);
    check({tag, "_RXDET"}, 32'(RXDET), 32'd0);
    check({tag, "_PHYSTATUS"}, 32'(PHYSTATUS), 32'd0);
    check({tag, "_RXSTATUS"}, 32'(RXSTATUS), 32'd0);
    check({tag, "_BUSY"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int busy_cnt, phys_cnt;
    model_reset();
    @(posedge clock);
    #1;
    check_reset_values("por");
    Reset_n = 1'b1;

    idle_cycles(3);
    run_req(3'b111, 0, 1'b0);
    idle_cycles(2);
    run_req(3'b000, 0, 1'b0);
    run_req(3'b101, 0, 1'b0);
    run_req(3'b010, 0, 1'b0);
    run_req(3'b110, 18, 1'b0);

    // Request without electrical idle must be ignored.
    busy_cnt = 0;
    phys_cnt = 0;
    TXELECIDLE = 1'b0;
    TXDETECTRX = 1'b1;
    for (int i = 0; i < 10; i++) begin
      RXDET_O = 1'($urandom);
      step();
      if (BUSY) busy_cnt++;
      if (PHYSTATUS) phys_cnt++;
    end
    check("noeidle_busy", busy_cnt, 0);
    check("noeidle_phys", phys_cnt, 0);
    idle_cycles(2);

    // Abort mid-DETECT with an asynchronous reset pulse after edge 7.
    TXELECIDLE = 1'b1;
    TXDETECTRX = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      RXDET_O = 1'b1;
      step();
    end
    check("rxdet_before_abort", 32'(RXDET), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_values("abort");
    model_reset();
    TXDETECTRX = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("abort_held");
    Reset_n = 1'b1;
    idle_cycles(1);
    run_req(3'b011, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      run_req(3'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
    end
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
